// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO read-domain blocks.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int BUF_DEPTH       = 2;

    typedef logic [1:0]                 level_t;
    typedef logic [FIFO_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry circular output buffer: written at the tail by returning read data,
// drained at the head by the downstream consumer.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_count,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic                  r_head;
    logic                  r_tail;
    logic [1:0]            r_count;

    // A write and a pop on the same edge leave the count unchanged; the popped
    // word is read combinationally before the edge, so order is preserved.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_wr) begin
                r_mem[r_tail] <= i_wdata;
                r_tail        <= ~r_tail;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, i_wr} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_valid = (r_count != 2'd0);

endmodule

// File: rtl/rd_stream_adapter.sv
// Turns the registered-read FIFO memory plus the empty flag into a
// first-word-fall-through valid/ready stream sustaining one word per cycle.
module rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            level
);

    logic       r_inflight;
    logic       w_pop;
    logic [1:0] w_count;
    logic [2:0] w_credit;

    // Handshake: a word transfers on every rising edge where m_valid & m_ready;
    // m_valid never depends on m_ready, and m_data holds while m_valid & !m_ready.
    assign w_pop = m_valid & m_ready;

    // Slots committed after this edge; a pop this cycle frees one, which is why
    // m_ready feeds r_en combinationally (keeps full throughput).
    assign w_credit = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign r_en     = !rrst && !empty && (w_credit < 3'(BUF_DEPTH));

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= r_en;
        end
    end

    rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .i_clk   (rclk),
        .i_rst   (rrst),
        .i_wr    (r_inflight),
        .i_wdata (rdata),
        .i_pop   (w_pop),
        .o_head  (m_data),
        .o_count (w_count),
        .o_valid (m_valid)
    );

    assign level = w_count;

endmodule
